// File: rtl/cvp_pwr_regfile.sv
// CVP power-control register bank behind the asynchronous pwr_* four-phase link.
// Entry 0 is a read-only view of status_i; entries 1..NUM_REGS-1 are byte-writable.

module cvp_pwr_regfile_entry #(
  parameter logic [63:0] RST_VAL = 64'h0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        we,
  input  logic [7:0]  be,
  input  logic [63:0] wdata,
  output logic [63:0] q
);
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      q <= RST_VAL;
    end else if (we) begin
      for (int b = 0; b < 8; b++)
        if (be[b]) q[8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

module cvp_pwr_regfile #(
  parameter int          NUM_REGS = 16,
  parameter logic [63:0] RST_VAL  = 64'h0
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     pwr_req,
  input  logic                     pwr_wr_rd,
  input  logic [28:0]              pwr_add,
  input  logic [7:0]               pwr_be,
  input  logic [63:0]              pwr_data,
  output logic                     pwr_ack,
  output logic                     pwr_error,
  output logic [63:0]              pwr_r_data,
  input  logic [63:0]              status_i,
  output logic [NUM_REGS*64-1:0]   pwr_ctrl_o
);
  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, ACK = 2'd2} state_t;

  state_t                     state, state_nxt;
  logic                       req_s0, req_s, cap_en;
  logic                       cap_wr_rd;
  logic [28:0]                cap_add;
  logic [7:0]                 cap_be;
  logic [63:0]                cap_data;
  logic [IDX_W-1:0]           idx;
  logic                       oor;
  logic [NUM_REGS-1:0][63:0]  regs;

  assign idx = cap_add[IDX_W-1:0];
  assign oor = (cap_add >> IDX_W) != 29'd0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      req_s0 <= 1'b0;
      req_s  <= 1'b0;
      state  <= IDLE;
    end else begin
      req_s0 <= pwr_req;
      req_s  <= req_s0;
      state  <= state_nxt;
    end
  end

  // ACCESS always advances, so a request dropped early still gets a one-cycle ack.
  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    case (state)
      IDLE: if (req_s) begin
        cap_en    = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = ACK;
      ACK:     if (!req_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cap_wr_rd <= 1'b0;
      cap_add   <= '0;
      cap_be    <= '0;
      cap_data  <= '0;
    end else if (cap_en) begin
      cap_wr_rd <= pwr_wr_rd;
      cap_add   <= pwr_add;
      cap_be    <= pwr_be;
      cap_data  <= pwr_data;
    end
  end

  assign regs[0] = 64'h0;

  for (genvar k = 1; k < NUM_REGS; k++) begin : g_entry
    cvp_pwr_regfile_entry #(.RST_VAL(RST_VAL)) u_entry (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .we      ((state == ACCESS) && !cap_wr_rd && !oor && (idx == IDX_W'(k))),
      .be      (cap_be),
      .wdata   (cap_data),
      .q       (regs[k])
    );
  end

  assign pwr_ctrl_o = regs;

  // Response flops hold their value through IDLE so a late-sampling bridge still sees them.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pwr_ack    <= 1'b0;
      pwr_error  <= 1'b0;
      pwr_r_data <= 64'h0;
    end else begin
      pwr_ack <= (state_nxt == ACK);
      if (state == ACCESS) begin
        if (cap_wr_rd) begin
          if (oor) begin
            pwr_r_data <= 64'h0;
            pwr_error  <= 1'b1;
          end else if (idx == '0) begin
            pwr_r_data <= status_i;
            pwr_error  <= 1'b0;
          end else begin
            pwr_r_data <= regs[idx];
            pwr_error  <= 1'b0;
          end
        end else begin
          pwr_error <= oor || (idx == '0);
        end
      end
    end
  end
endmodule
